// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display readback path.
// Holds the active-low segment pattern constants (bit order g..a),
// the non-digit result codes, and the scan decoder FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG7_PAT_0    = 7'h40;
    localparam logic [6:0] SEG7_PAT_1    = 7'h79;
    localparam logic [6:0] SEG7_PAT_2    = 7'h24;
    localparam logic [6:0] SEG7_PAT_3    = 7'h30;
    localparam logic [6:0] SEG7_PAT_4    = 7'h19;
    localparam logic [6:0] SEG7_PAT_5    = 7'h12;
    localparam logic [6:0] SEG7_PAT_6    = 7'h02;
    localparam logic [6:0] SEG7_PAT_7    = 7'h78;
    localparam logic [6:0] SEG7_PAT_8    = 7'h00;
    localparam logic [6:0] SEG7_PAT_9    = 7'h10;
    localparam logic [6:0] SEG7_PAT_DASH = 7'h3F;

    localparam logic [3:0] SEG7_CODE_DASH = 4'hF;
    localparam logic [3:0] SEG7_CODE_BAD  = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern decoder (active-low, bits g..a).
// Ports:
//   pattern  in  7  segment pattern, dp already removed
//   data     out 4  decoded digit, SEG7_CODE_DASH for '-', SEG7_CODE_BAD otherwise
//   err      out 1  pattern is not a legal digit or dash
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] data,
    output logic       err
);

    always_comb begin
        data = SEG7_CODE_BAD;
        err  = 1'b1;
        case (pattern)
            SEG7_PAT_0:    begin data = 4'd0;           err = 1'b0; end
            SEG7_PAT_1:    begin data = 4'd1;           err = 1'b0; end
            SEG7_PAT_2:    begin data = 4'd2;           err = 1'b0; end
            SEG7_PAT_3:    begin data = 4'd3;           err = 1'b0; end
            SEG7_PAT_4:    begin data = 4'd4;           err = 1'b0; end
            SEG7_PAT_5:    begin data = 4'd5;           err = 1'b0; end
            SEG7_PAT_6:    begin data = 4'd6;           err = 1'b0; end
            SEG7_PAT_7:    begin data = 4'd7;           err = 1'b0; end
            SEG7_PAT_8:    begin data = 4'd8;           err = 1'b0; end
            SEG7_PAT_9:    begin data = 4'd9;           err = 1'b0; end
            SEG7_PAT_DASH: begin data = SEG7_CODE_DASH; err = 1'b0; end
            default:       begin data = SEG7_CODE_BAD;  err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed 7-segment display bus. Waits for each
// digit's (anode, segment) pair to be stable for STABLE_CYCLES samples,
// decodes it into a per-digit register bank and raises a valid/ready
// change event when a digit's decoded content changes.
// Optional macro SEG7_DP_CAPTURE_EN: adds dp_out and includes seg_in[7]
// in the stability compare and change detection.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   seg_in[7:0]          active-low segments, bit7 = dp
//   an_in[DIGITS-1:0]    active-low one-hot anode strobe
//   digit_out            decoded bank, digit i at [4i+3:4i]
//   digit_vld/digit_err  per-digit captured / last capture illegal
//   upd_*                change event stream; upd_ovf sticky overwrite flag
//   dp_out               (macro only) last captured decimal point per digit
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  seg_in,
    input  logic [DIGITS-1:0]           an_in,
    output logic [4*DIGITS-1:0]         digit_out,
    output logic [DIGITS-1:0]           digit_vld,
    output logic [DIGITS-1:0]           digit_err,
    output logic                        upd_valid,
    input  logic                        upd_ready,
    output logic [$clog2(DIGITS)-1:0]   upd_idx,
    output logic [3:0]                  upd_data,
    output logic                        upd_err,
    output logic                        upd_ovf
`ifdef SEG7_DP_CAPTURE_EN
    ,
    output logic [DIGITS-1:0]           dp_out
`endif
);

    localparam int IDXW = $clog2(DIGITS);
`ifdef SEG7_DP_CAPTURE_EN
    localparam int CMPW = 8;
`else
    localparam int CMPW = 7;
    logic unused_dp;
    assign unused_dp = seg_in[7];
`endif
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_FULL = 8'(STABLE_CYCLES);

    seg7_state_e       state, state_nx;
    logic [7:0]        cnt, cnt_nx;
    logic [DIGITS-1:0] an_lat, an_lat_nx;
    logic [CMPW-1:0]   seg_lat, seg_lat_nx;
    logic [CMPW-1:0]   seg_cmp;
    logic [DIGITS-1:0] an_act;
    logic              an_ok, same, capture, changed;
    logic [IDXW-1:0]   cap_idx;
    logic [3:0]        dec_data;
    logic              dec_err;

    assign seg_cmp = seg_in[CMPW-1:0];
    assign an_act  = ~an_in;
    // exactly one active anode: non-zero and a power of two
    assign an_ok   = (an_act != '0) && ((an_act & (an_act - 1'b1)) == '0);
    assign same    = (an_in == an_lat) && (seg_cmp == seg_lat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            an_lat  <= '1;
            seg_lat <= '1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            an_lat  <= an_lat_nx;
            seg_lat <= seg_lat_nx;
        end
    end

    // The first matching sample is the latch itself (cnt=1), so capture
    // fires on the edge that takes the STABLE_CYCLES-th identical sample.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        an_lat_nx  = an_lat;
        seg_lat_nx = seg_lat;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (an_ok) begin
                    an_lat_nx  = an_in;
                    seg_lat_nx = seg_cmp;
                    cnt_nx     = 8'd1;
                    state_nx   = SETTLE;
                end
            end
            SETTLE: begin
                if (!an_ok) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (same) begin
                    if (cnt >= CNT_LAST) begin
                        capture  = 1'b1;
                        cnt_nx   = CNT_FULL;
                        state_nx = HOLD;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end else begin
                    an_lat_nx  = an_in;
                    seg_lat_nx = seg_cmp;
                    cnt_nx     = 8'd1;
                end
            end
            HOLD: begin
                if (!an_ok) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (!same) begin
                    an_lat_nx  = an_in;
                    seg_lat_nx = seg_cmp;
                    cnt_nx     = 8'd1;
                    state_nx   = SETTLE;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        cap_idx = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!an_lat[i]) cap_idx = IDXW'(i);
        end
    end

    seg7_pattern_decode u_decode (
        .pattern (seg_lat[6:0]),
        .data    (dec_data),
        .err     (dec_err)
    );

    always_comb begin
        changed = !digit_vld[cap_idx]
               || (dec_data != digit_out[4*cap_idx +: 4])
               || (dec_err  != digit_err[cap_idx]);
`ifdef SEG7_DP_CAPTURE_EN
        changed = changed || (dp_out[cap_idx] != ~seg_lat[7]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_out <= '0;
            digit_vld <= '0;
            digit_err <= '0;
`ifdef SEG7_DP_CAPTURE_EN
            dp_out    <= '0;
`endif
        end else if (capture) begin
            digit_out[4*cap_idx +: 4] <= dec_data;
            digit_vld[cap_idx]        <= 1'b1;
            digit_err[cap_idx]        <= dec_err;
`ifdef SEG7_DP_CAPTURE_EN
            dp_out[cap_idx]           <= ~seg_lat[7];
`endif
        end
    end

    // A new event always wins: it overwrites unaccepted fields (flagging
    // overflow) or becomes the next pending event on an accept cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid <= 1'b0;
            upd_idx   <= '0;
            upd_data  <= '0;
            upd_err   <= 1'b0;
            upd_ovf   <= 1'b0;
        end else if (capture && changed) begin
            if (upd_valid && !upd_ready) upd_ovf <= 1'b1;
            upd_valid <= 1'b1;
            upd_idx   <= cap_idx;
            upd_data  <= dec_data;
            upd_err   <= dec_err;
        end else if (upd_valid && upd_ready) begin
            upd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=4).
// Expected change events are queued as stimulus is driven and compared
// against each accepted upd_* transfer.
module tb_seg7_scan_decoder;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] data;
        logic       err;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digit_out;
    logic [3:0]  digit_vld;
    logic [3:0]  digit_err;
    logic        upd_valid;
    logic        upd_ready;
    logic [1:0]  upd_idx;
    logic [3:0]  upd_data;
    logic        upd_err;
    logic        upd_ovf;

    int total = 0;
    int bad   = 0;
    ev_t exp_q[$];

    seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .an_in     (an_in),
        .digit_out (digit_out),
        .digit_vld (digit_vld),
        .digit_err (digit_err),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_idx   (upd_idx),
        .upd_data  (upd_data),
        .upd_err   (upd_err),
        .upd_ovf   (upd_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; a transfer seen before the edge is scored against the queue.
    task automatic tick();
        ev_t e;
        if (upd_valid && upd_ready) begin
            chk("ev_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ev_idx",  32'(upd_idx),  32'(e.idx));
                chk("ev_data", 32'(upd_data), 32'(e.data));
                chk("ev_err",  32'(upd_err),  32'(e.err));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic push(input logic [1:0] idx, input logic [3:0] data, input logic err);
        ev_t e;
        e.idx  = idx;
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    initial begin
        rst       = 1'b1;
        an_in     = 4'b1111;
        seg_in    = 8'hFF;
        upd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_digit_out", 32'(digit_out), 32'h0);
        chk("rst_vld",       32'(digit_vld), 32'h0);
        chk("rst_valid",     32'(upd_valid), 32'h0);

        // digit 0 = '2': not captured after 3 samples, captured on the 4th
        hold(4'b1110, 8'hA4, 3);
        chk("t1_vld_early",   32'(digit_vld), 32'h0);
        chk("t1_valid_early", 32'(upd_valid), 32'h0);
        push(2'd0, 4'd2, 1'b0);
        tick();
        chk("t1_digit0", 32'(digit_out[3:0]), 32'h2);
        chk("t1_vld",    32'(digit_vld), 32'h1);
        chk("t1_valid",  32'(upd_valid), 32'h1);
        chk("t1_idx",    32'(upd_idx),   32'h0);
        chk("t1_data",   32'(upd_data),  32'h2);
        for (int k = 0; k < 5; k++) tick();
        chk("t1_stable_valid", 32'(upd_valid), 32'h1);
        chk("t1_no_ovf",       32'(upd_ovf),   32'h0);
        upd_ready = 1'b1;
        tick();
        chk("t1_dropped", 32'(upd_valid), 32'h0);
        for (int k = 0; k < 4; k++) tick();
        chk("t1_no_repeat", 32'(upd_valid), 32'h0);

        // scan all four digits
        push(2'd0, 4'h0, 1'b0);
        hold(4'b1110, 8'hC0, 6);
        push(2'd1, 4'h1, 1'b0);
        hold(4'b1101, 8'hF9, 6);
        push(2'd2, 4'hF, 1'b0);
        hold(4'b1011, 8'hBF, 6);
        push(2'd3, 4'h5, 1'b0);
        hold(4'b0111, 8'h92, 6);
        chk("t2_bank", 32'(digit_out), 32'h5F10);
        chk("t2_vld",  32'(digit_vld), 32'hF);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3-cycle toggling never settles
        for (int k = 0; k < 2; k++) begin
            hold(4'b1101, 8'h80, 3);
            hold(4'b1101, 8'h90, 3);
        end
        hold(4'b1101, 8'h80, 3);
        chk("t3_toggle_digit1", 32'(digit_out[7:4]), 32'h1);
        chk("t3_toggle_valid",  32'(upd_valid), 32'h0);
        hold(4'b1101, 8'h90, 3);
        chk("t3_hold3_digit1", 32'(digit_out[7:4]), 32'h1);
        push(2'd1, 4'h9, 1'b0);
        tick();
        chk("t3_hold4_digit1", 32'(digit_out[7:4]), 32'h9);
        tick();

        // illegal pattern then a legal one on digit 2
        push(2'd2, 4'hE, 1'b1);
        hold(4'b1011, 8'hFF, 5);
        chk("t4_bad_data", 32'(digit_out[11:8]), 32'hE);
        chk("t4_bad_err",  32'(digit_err), 32'h4);
        push(2'd2, 4'h3, 1'b0);
        hold(4'b1011, 8'hB0, 5);
        chk("t4_good_data", 32'(digit_out[11:8]), 32'h3);
        chk("t4_good_err",  32'(digit_err), 32'h0);

        // overwrite of an unaccepted event
        upd_ready = 1'b0;
        hold(4'b1110, 8'hF9, 5);
        chk("t5_pending_idx", 32'(upd_idx), 32'h0);
        chk("t5_ovf_before",  32'(upd_ovf), 32'h0);
        push(2'd1, 4'h2, 1'b0);
        hold(4'b1101, 8'hA4, 5);
        chk("t5_idx",   32'(upd_idx),   32'h1);
        chk("t5_data",  32'(upd_data),  32'h2);
        chk("t5_ovf",   32'(upd_ovf),   32'h1);
        chk("t5_valid", 32'(upd_valid), 32'h1);
        upd_ready = 1'b1;
        tick();
        chk("t5_after_xfer", 32'(upd_valid), 32'h0);
        chk("t5_ovf_sticky", 32'(upd_ovf),   32'h1);

        // reset with an event pending and mid-SETTLE
        upd_ready = 1'b0;
        hold(4'b0111, 8'hC0, 4);
        chk("t6_pending", 32'(upd_valid), 32'h1);
        hold(4'b0111, 8'hF9, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_digit_out", 32'(digit_out), 32'h0);
        chk("t6_vld",       32'(digit_vld), 32'h0);
        chk("t6_err",       32'(digit_err), 32'h0);
        chk("t6_valid",     32'(upd_valid), 32'h0);
        chk("t6_idx",       32'(upd_idx),   32'h0);
        chk("t6_data",      32'(upd_data),  32'h0);
        chk("t6_uerr",      32'(upd_err),   32'h0);
        chk("t6_ovf",       32'(upd_ovf),   32'h0);
        hold(4'b1100, 8'hA4, 10);
        chk("t6_multi_vld",   32'(digit_vld), 32'h0);
        chk("t6_multi_valid", 32'(upd_valid), 32'h0);
        chk("final_q_empty",  32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
